// File: rtl/rv32i_types.sv
// Shared RV32I front-end types: predictor sizing and the BTB entry layout.
package rv32i_types;

  localparam int SIZE_GLOBAL = 8;
  localparam int BTB_IDX     = 4;
  localparam int BTB_TAG_W   = 30 - BTB_IDX;

  // Tag width follows the package BTB_IDX, so instances should keep the default BTB_IDX.
  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [31:0]          target;
    logic                 cond;
  } btb_entry_t;

endpackage

// File: rtl/pht_sat2.sv
// Pattern history table of 2-bit saturating counters with one
// combinational read port and one synchronous update port.
module pht_sat2 #(
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             upd_en,
  input  logic             upd_taken,
  input  logic [IDX_W-1:0] upd_idx
);

  localparam int NUM_CTR = 1 << IDX_W;

  logic [1:0] ctr [NUM_CTR];
  logic [1:0] upd_cur;
  logic [1:0] upd_next;

  // The read sees the stored value, so a same-cycle update is not forwarded.
  assign rd_ctr  = ctr[rd_idx];
  assign upd_cur = ctr[upd_idx];

  always_comb begin
    upd_next = upd_cur;
    if (upd_taken) begin
      if (upd_cur != 2'b11) upd_next = upd_cur + 2'd1;
    end else begin
      if (upd_cur != 2'b00) upd_next = upd_cur - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CTR; i++) ctr[i] <= 2'b01;
    end else if (upd_en) begin
      ctr[upd_idx] <= upd_next;
    end
  end

endmodule

// File: rtl/br_predictor.sv
// Gshare branch predictor: GHR-hashed PHT for direction, direct-mapped BTB
// for targets, zero-latency prediction and resolve-time training.
module br_predictor #(
  parameter int SIZE_GLOBAL = rv32i_types::SIZE_GLOBAL,
  parameter int BTB_IDX     = rv32i_types::BTB_IDX
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_req,
  input  logic [31:0]            fetch_pc,
  output logic                   pred_taken,
  output logic [31:0]            pred_target,
  output logic [SIZE_GLOBAL-1:0] pred_history,
  input  logic                   br_finish,
  input  logic                   br_op,
  input  logic                   br_en,
  input  logic [31:0]            br_pc,
  input  logic [31:0]            br_addr,
  input  logic [SIZE_GLOBAL-1:0] br_history_old,
  input  logic                   br_mispredict
);

  import rv32i_types::*;

  localparam int NUM_BTB = 1 << BTB_IDX;

  btb_entry_t             btb [NUM_BTB];
  btb_entry_t             fetch_entry;
  logic [SIZE_GLOBAL-1:0] ghr;
  logic [BTB_IDX-1:0]     fetch_btb_idx;
  logic [BTB_IDX-1:0]     upd_btb_idx;
  logic [BTB_TAG_W-1:0]   fetch_tag;
  logic [BTB_TAG_W-1:0]   upd_tag;
  logic                   fetch_hit;
  logic [1:0]             fetch_ctr;
  logic [SIZE_GLOBAL-1:0] fetch_pht_idx;
  logic [SIZE_GLOBAL-1:0] upd_pht_idx;
  logic                   unused_pc_bits;

  assign unused_pc_bits = ^{fetch_pc[1:0], br_pc[1:0]};

  assign fetch_btb_idx = fetch_pc[BTB_IDX+1:2];
  assign upd_btb_idx   = br_pc[BTB_IDX+1:2];
  assign fetch_tag     = fetch_pc[31:BTB_IDX+2];
  assign upd_tag       = br_pc[31:BTB_IDX+2];
  assign fetch_entry   = btb[fetch_btb_idx];
  assign fetch_hit     = fetch_entry.valid && (fetch_entry.tag == fetch_tag);

  assign fetch_pht_idx = fetch_pc[SIZE_GLOBAL+1:2] ^ ghr;
  assign upd_pht_idx   = br_pc[SIZE_GLOBAL+1:2] ^ br_history_old;

  // Unconditional jumps that hit are always taken; conditional ones follow the counter MSB.
  assign pred_taken   = !rst && fetch_req && fetch_hit && (!fetch_entry.cond || fetch_ctr[1]);
  assign pred_target  = pred_taken ? fetch_entry.target : fetch_pc + 32'd4;
  assign pred_history = ghr;

  pht_sat2 #(
    .IDX_W(SIZE_GLOBAL)
  ) u_pht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (fetch_pht_idx),
    .rd_ctr   (fetch_ctr),
    .upd_en   (br_finish && br_op),
    .upd_taken(br_en),
    .upd_idx  (upd_pht_idx)
  );

  // A resolved mispredict rebuilds history from the fetch-time snapshot and wins over speculation.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr <= '0;
    end else if (br_finish && br_mispredict) begin
      ghr <= br_op ? {br_history_old[SIZE_GLOBAL-2:0], br_en} : br_history_old;
    end else if (fetch_req && fetch_hit && fetch_entry.cond) begin
      ghr <= {ghr[SIZE_GLOBAL-2:0], pred_taken};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_BTB; i++) btb[i].valid <= 1'b0;
    end else if (br_finish && br_en) begin
      btb[upd_btb_idx] <= '{valid: 1'b1, tag: upd_tag, target: br_addr, cond: br_op};
    end
  end

endmodule

// File: tb/tb_br_predictor.sv
// Scoreboard bench for br_predictor: directed fetch/update vectors push
// hand-computed predictions; a negedge monitor pops and compares them.
module tb_br_predictor;

  localparam int SG = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_req;
  logic [31:0]   fetch_pc;
  logic          pred_taken;
  logic [31:0]   pred_target;
  logic [SG-1:0] pred_history;
  logic          br_finish;
  logic          br_op;
  logic          br_en;
  logic [31:0]   br_pc;
  logic [31:0]   br_addr;
  logic [SG-1:0] br_history_old;
  logic          br_mispredict;

  typedef struct packed {
    logic          rst;
    logic          f_req;
    logic [31:0]   f_pc;
    logic          b_fin;
    logic          b_op;
    logic          b_en;
    logic [31:0]   b_pc;
    logic [31:0]   b_addr;
    logic [SG-1:0] b_hist;
    logic          b_mis;
  } stim_t;

  typedef struct packed {
    logic [31:0]   pc;
    logic          taken;
    logic [31:0]   target;
    logic [SG-1:0] hist;
  } exp_t;

  exp_t sb_q [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  br_predictor #(
    .SIZE_GLOBAL(SG),
    .BTB_IDX    (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_req     (fetch_req),
    .fetch_pc      (fetch_pc),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target),
    .pred_history  (pred_history),
    .br_finish     (br_finish),
    .br_op         (br_op),
    .br_en         (br_en),
    .br_pc         (br_pc),
    .br_addr       (br_addr),
    .br_history_old(br_history_old),
    .br_mispredict (br_mispredict)
  );

  always #5 clk = ~clk;

  function automatic stim_t fetch_s(input logic [31:0] pc);
    stim_t s;
    s = '0;
    s.f_req = 1'b1;
    s.f_pc  = pc;
    return s;
  endfunction

  function automatic stim_t upd_s(input logic op, input logic en, input logic [31:0] pc,
                                  input logic [31:0] addr, input logic [SG-1:0] hist,
                                  input logic mis);
    stim_t s;
    s = '0;
    s.b_fin  = 1'b1;
    s.b_op   = op;
    s.b_en   = en;
    s.b_pc   = pc;
    s.b_addr = addr;
    s.b_hist = hist;
    s.b_mis  = mis;
    return s;
  endfunction

  task automatic driveIdle();
    rst            = 1'b0;
    fetch_req      = 1'b0;
    fetch_pc       = '0;
    br_finish      = 1'b0;
    br_op          = 1'b0;
    br_en          = 1'b0;
    br_pc          = '0;
    br_addr        = '0;
    br_history_old = '0;
    br_mispredict  = 1'b0;
  endtask

  task automatic applyStimulus(input stim_t s, input exp_t e);
    rst            = s.rst;
    fetch_req      = s.f_req;
    fetch_pc       = s.f_pc;
    br_finish      = s.b_fin;
    br_op          = s.b_op;
    br_en          = s.b_en;
    br_pc          = s.b_pc;
    br_addr        = s.b_addr;
    br_history_old = s.b_hist;
    br_mispredict  = s.b_mis;
    if (s.f_req) sb_q.push_back(e);
    @(posedge clk);
    #1;
    driveIdle();
  endtask

  function automatic exp_t mk_exp(input logic [31:0] pc, input logic taken,
                                  input logic [31:0] target, input logic [SG-1:0] hist);
    exp_t e;
    e.pc     = pc;
    e.taken  = taken;
    e.target = target;
    e.hist   = hist;
    return e;
  endfunction

  task automatic doFetch(input logic [31:0] pc, input logic taken,
                         input logic [31:0] target, input logic [SG-1:0] hist);
    applyStimulus(fetch_s(pc), mk_exp(pc, taken, target, hist));
  endtask

  task automatic doUpdate(input logic op, input logic en, input logic [31:0] pc,
                          input logic [31:0] addr, input logic [SG-1:0] hist, input logic mis);
    applyStimulus(upd_s(op, en, pc, addr, hist, mis), '0);
  endtask

  // A jal-class mispredict with br_en=0 reloads the GHR without touching PHT or BTB.
  task automatic restoreGhr(input logic [SG-1:0] hist);
    doUpdate(1'b0, 1'b0, 32'h300, 32'h0, hist, 1'b1);
  endtask

  task automatic checkOutput(input exp_t e);
    n_cmp++;
    if (pred_taken !== e.taken) begin
      n_bad++;
      $display("[TB] FAIL pred_taken pc=%h: got %b expected %b", e.pc, pred_taken, e.taken);
    end
    n_cmp++;
    if (pred_target !== e.target) begin
      n_bad++;
      $display("[TB] FAIL pred_target pc=%h: got %h expected %h", e.pc, pred_target, e.target);
    end
    n_cmp++;
    if (pred_history !== e.hist) begin
      n_bad++;
      $display("[TB] FAIL pred_history pc=%h: got %h expected %h", e.pc, pred_history, e.hist);
    end
  endtask

  // Monitor: every presented fetch must match the oldest queued expectation.
  always @(negedge clk) begin
    if (fetch_req) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL unexpected_fetch pc=%h: got a fetch expected none", fetch_pc);
      end else begin
        checkOutput(sb_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t s;
    driveIdle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    s = '0;
    s.rst = 1'b1;
    applyStimulus(s, '0);

    $display("[TB] reset state");
    doFetch(32'h60, 1'b0, 32'h64, 8'h00);

    $display("[TB] train conditional branch at 0x100");
    doUpdate(1'b1, 1'b1, 32'h100, 32'h80, 8'h00, 1'b0);
    doUpdate(1'b1, 1'b1, 32'h100, 32'h80, 8'h00, 1'b0);
    doFetch(32'h100, 1'b1, 32'h80, 8'h00);
    doFetch(32'h60, 1'b0, 32'h64, 8'h01);

    $display("[TB] reset discards training");
    s = '0;
    s.rst = 1'b1;
    applyStimulus(s, '0);
    doFetch(32'h100, 1'b0, 32'h104, 8'h00);

    $display("[TB] counter saturation");
    for (int i = 0; i < 5; i++) doUpdate(1'b1, 1'b1, 32'h100, 32'h80, 8'h00, 1'b0);
    doFetch(32'h100, 1'b1, 32'h80, 8'h00);
    restoreGhr(8'h00);
    doUpdate(1'b1, 1'b0, 32'h100, 32'h0, 8'h00, 1'b0);
    doFetch(32'h100, 1'b1, 32'h80, 8'h00);
    restoreGhr(8'h00);
    doUpdate(1'b1, 1'b0, 32'h100, 32'h0, 8'h00, 1'b0);
    doUpdate(1'b1, 1'b0, 32'h100, 32'h0, 8'h00, 1'b0);
    doFetch(32'h100, 1'b0, 32'h104, 8'h00);

    $display("[TB] mispredict restore overrides speculative shift");
    restoreGhr(8'hFF);
    s = upd_s(1'b1, 1'b0, 32'h100, 32'h0, 8'h12, 1'b1);
    s.f_req = 1'b1;
    s.f_pc  = 32'h100;
    applyStimulus(s, mk_exp(32'h100, 1'b0, 32'h104, 8'hFF));
    doFetch(32'h60, 1'b0, 32'h64, 8'h24);

    $display("[TB] mispredict without finish is ignored");
    s = '0;
    s.b_mis  = 1'b1;
    s.b_hist = 8'h55;
    applyStimulus(s, '0);
    doFetch(32'h60, 1'b0, 32'h64, 8'h24);

    $display("[TB] jal leaves PHT and GHR alone");
    doUpdate(1'b0, 1'b1, 32'h200, 32'h400, 8'hC0, 1'b0);
    doUpdate(1'b0, 1'b1, 32'h200, 32'h400, 8'hC0, 1'b0);
    doFetch(32'h200, 1'b1, 32'h400, 8'h24);
    doFetch(32'h60, 1'b0, 32'h64, 8'h24);
    restoreGhr(8'h00);
    doUpdate(1'b1, 1'b1, 32'h100, 32'h80, 8'h00, 1'b0);
    doFetch(32'h100, 1'b0, 32'h104, 8'h00);

    repeat (2) @(posedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
